// File: rtl/demux_1a2_ochobitsl1.sv
// Receive-side 1:2 byte demux: deals valid bytes alternately to lane 0 / lane 1, with per-lane counters.
// Latency: 1 clk from data_in/valid_in to data_outX/valid_outX; lane_sel is registered.
// Backpressure: none; every valid byte is accepted, and invalid cycles leave the lane position unchanged.
module demux_1a2_ochobitsl1 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [7:0]       data_in,
    input  logic             valid_in,
    input  logic             realign,
    output logic [7:0]       data_out0,
    output logic [7:0]       data_out1,
    output logic             valid_out0,
    output logic             valid_out1,
    output logic             lane_sel,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1
);

    // realign overrides the stored selector for this cycle only
    logic esel;
    assign esel = realign ? 1'b0 : lane_sel;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out0  <= 8'h00;
            data_out1  <= 8'h00;
            valid_out0 <= 1'b0;
            valid_out1 <= 1'b0;
            lane_sel   <= 1'b0;
            count0     <= '0;
            count1     <= '0;
        end else if (valid_in) begin
            lane_sel <= ~esel;
            if (esel == 1'b0) begin
                data_out0  <= data_in;
                valid_out0 <= 1'b1;
                valid_out1 <= 1'b0;
                count0     <= count0 + CNT_W'(1);
            end else begin
                data_out1  <= data_in;
                valid_out0 <= 1'b0;
                valid_out1 <= 1'b1;
                count1     <= count1 + CNT_W'(1);
            end
        end else begin
            valid_out0 <= 1'b0;
            valid_out1 <= 1'b0;
            lane_sel   <= esel;
        end
    end

endmodule

// File: tb/tb_demux_1a2_ochobitsl1.sv
// Scoreboarded bench for demux_1a2_ochobitsl1: directed bytes push expected lane/data/count, a monitor pops on valid_out.
module tb_demux_1a2_ochobitsl1;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       realign = 1'b0;
    logic [7:0] data_out0, data_out1;
    logic       valid_out0, valid_out1, lane_sel;
    logic [7:0] count0, count1;

    demux_1a2_ochobitsl1 #(.CNT_W(8)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .realign    (realign),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .lane_sel   (lane_sel),
        .count0     (count0),
        .count1     (count1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lane;
        logic [7:0] dat;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        if (reset_L) begin
            if (valid_out0 && valid_out1)
                check("both_valid", 1, 0);
            else if (valid_out0 || valid_out1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {valid_out1, valid_out0}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("lane", {31'd0, valid_out1}, {31'd0, e.lane});
                    check("data", e.lane ? data_out1 : data_out0, e.dat);
                    check("count", e.lane ? count1 : count0, e.cnt);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic ra, input logic lane, input logic [7:0] cnt);
        exp_t e;
        @(negedge clk);
        data_in  = d;
        valid_in = 1'b1;
        realign  = ra;
        e.lane = lane;
        e.dat  = d;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic ra);
        @(negedge clk);
        valid_in = 1'b0;
        realign  = ra;
        data_in  = 8'hEE;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_d0"}, data_out0, 0);
        check({tag, "_d1"}, data_out1, 0);
        check({tag, "_v"}, {valid_out1, valid_out0}, 0);
        check({tag, "_sel"}, lane_sel, 0);
        check({tag, "_c0"}, count0, 0);
        check({tag, "_c1"}, count1, 0);
    endtask

    // Asynchronous reset pulse placed strictly between clock edges
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        valid_in = 1'b0;
        realign  = 1'b0;
        #1 reset_L = 1'b0;
        #1 check_cleared(tag);
        #1 reset_L = 1'b1;
    endtask

    initial begin
        // Reset held with random inputs
        repeat (3) begin
            @(negedge clk);
            data_in  = 8'($urandom);
            valid_in = 1'($urandom);
            realign  = 1'($urandom);
        end
        check_cleared("rst_hold");
        @(negedge clk);
        valid_in = 1'b0;
        realign  = 1'b0;
        reset_L  = 1'b1;
        repeat (2) after_edge();
        check_cleared("rst_release");

        // Back-to-back bytes
        send(8'hA1, 1'b0, 1'b0, 8'd1);
        send(8'hB2, 1'b0, 1'b1, 8'd1);
        send(8'hC3, 1'b0, 1'b0, 8'd2);
        send(8'hD4, 1'b0, 1'b1, 8'd2);
        idle(1'b0);
        after_edge();
        check("b2b_c0", count0, 2);
        check("b2b_c1", count1, 2);
        check("b2b_sel", lane_sel, 0);

        // Gap holds position
        send(8'h11, 1'b0, 1'b0, 8'd3);
        repeat (3) begin
            idle(1'b0);
            after_edge();
        end
        check("gap_hold_d0", data_out0, 8'h11);
        check("gap_sel", lane_sel, 1);
        send(8'h22, 1'b0, 1'b1, 8'd3);

        // Realign with valid, then realign alone
        send(8'h55, 1'b0, 1'b0, 8'd4);
        after_edge();
        check("ra_pre_sel", lane_sel, 1);
        send(8'h66, 1'b1, 1'b0, 8'd5);
        after_edge();
        check("ra_d0", data_out0, 8'h66);
        check("ra_sel_after_valid", lane_sel, 1);
        idle(1'b1);
        after_edge();
        check("ra_idle_sel", lane_sel, 0);
        check("ra_idle_d0", data_out0, 8'h66);

        // Reset mid-operation
        send(8'h01, 1'b0, 1'b0, 8'd6);
        send(8'h02, 1'b0, 1'b1, 8'd4);
        send(8'h03, 1'b0, 1'b0, 8'd7);
        after_edge();
        check("mid_sel", lane_sel, 1);
        reset_pulse("mid_rst");
        send(8'h77, 1'b0, 1'b0, 8'd1);
        after_edge();
        check("post_rst_sel", lane_sel, 1);

        // Counter wrap from a clean start
        reset_pulse("wrap_rst");
        for (int i = 0; i < 512; i++) begin
            send(8'(i), 1'b0, 1'(i % 2), 8'((i / 2) + 1));
            if (i == 509) begin
                after_edge();
                check("wrap510_c0", count0, 8'hFF);
                check("wrap510_c1", count1, 8'hFF);
            end
        end
        idle(1'b0);
        after_edge();
        check("wrap512_c0", count0, 0);
        check("wrap512_c1", count1, 0);
        check("wrap512_sel", lane_sel, 0);

        repeat (3) begin
            idle(1'b0);
            after_edge();
        end
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/demux_1a2_ochobitsl1.md
Name: demux_1a2_ochobitsL1

Overview:
- Sequential 1-to-2 byte demultiplexer on the receive side of the PHY. It is the inverse of the transmit-side 2-to-1 byte mux.
- Takes one 8-bit byte stream with a valid bit and deals valid bytes alternately to lane 0 and lane 1.
- Output registers carry per-lane valid bits, plus per-lane byte counters for link bring-up checks.
- A realign input forces the next valid byte onto lane 0, so the lane order matches the transmitter.

Parameters:
- CNT_W, 8, width of each per-lane byte counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- data_in  input  8  incoming byte.
- valid_in  input  1  data_in is a valid byte this cycle.
- realign  input  1  force the lane selector to lane 0 this cycle.
- data_out0  output  8  registered byte for lane 0.
- data_out1  output  8  registered byte for lane 1.
- valid_out0  output  1  data_out0 was written on the last edge.
- valid_out1  output  1  data_out1 was written on the last edge.
- lane_sel  output  1  current selector: lane that the next valid byte will go to.
- count0  output  CNT_W  number of valid bytes delivered to lane 0.
- count1  output  CNT_W  number of valid bytes delivered to lane 1.

Behaviour:
- Reset:
  - reset_L low clears all registers asynchronously: data_out0 = data_out1 = 8'h00, valid_out0 = valid_out1 = 0, lane_sel = 0, count0 = count1 = 0.
  - Registers stay cleared while reset_L is low.
  - Deassertion takes effect at the first clk edge after reset_L rises.
  - Reset mid-stream discards the pending lane position; the first valid byte after reset goes to lane 0.
- Effective selector: esel = realign ? 0 : lane_sel.
- Rising edge with valid_in = 1:
  - The esel lane register loads data_in.
  - That lane's valid_out goes to 1 and the other lane's valid_out goes to 0.
  - That lane's counter increments.
  - lane_sel becomes ~esel.
- Rising edge with valid_in = 0:
  - valid_out0 = valid_out1 = 0.
  - data_out0/1 hold their last values; counters hold.
  - lane_sel becomes esel: realign alone resets the selector to 0, otherwise it holds.
- Latency: exactly 1 clk from data_in/valid_in sampled to data_outX/valid_outX.
- At most one valid_out is high in any cycle; never both.
- Gaps: invalid cycles do not advance the lane position. Byte order is preserved across gaps of any length.
- Realign and valid together: the byte goes to lane 0 regardless of lane_sel, and lane_sel becomes 1. If the previous byte also went to lane 0, lane 0 is written twice in a row; no error is flagged.
- Counters: count0/count1 are free-running and wrap from 2^CNT_W-1 to 0 with no saturation. They are updated in the same edge as the data.
- Data path: purely registered, no combinational path from inputs to outputs. lane_sel is a registered output and does not reflect same-cycle realign.

Test Plan:
- Reset check: reset_L = 0 with random inputs, then release -> all outputs 0, lane_sel = 0, and outputs stay 0 while valid_in = 0.
- Back-to-back bytes: valid_in = 1 continuously with data 8'hA1, 8'hB2, 8'hC3, 8'hD4 ->
  - next cycles show out0 = A1/v0 = 1; out1 = B2/v1 = 1; out0 = C3; out1 = D4;
  - valid bits alternate and are never both high;
  - finally count0 = 2, count1 = 2.
- Gap holds position: send 8'h11 (valid), 3 invalid cycles, then 8'h22 (valid) ->
  - 8'h11 on lane 0 and 8'h22 on lane 1;
  - both valids are 0 during the gap, and data_out0 holds 8'h11.
- Realign:
  - send 8'h55 (goes to lane 0, lane_sel = 1), then 8'h66 with realign = 1 -> 8'h66 appears on lane 0, count0 = 2, lane_sel = 1.
  - realign = 1 with valid_in = 0 while lane_sel = 1 -> lane_sel = 0 next cycle.
- Counter wrap: CNT_W = 8, send 512 valid bytes -> count0 = count1 = 0 after wrap; at 510 bytes count0 = count1 = 8'hFF.
- Reset mid-operation: after 3 valid bytes (lane_sel = 1), pulse reset_L low between edges ->
  - outputs clear immediately, without waiting for a clk edge;
  - the next valid byte 8'h77 lands on lane 0 with count0 = 1.
